// File: rtl/bsram_be_clear.sv
// bsram_be_clear: single-read / single-write block RAM with byte strobes,
// write-first bypass, selectable read latency (0 or 1) and a post-reset
// hardware clear sweep that makes memory contents deterministic.
module bsram_be_clear #(
    parameter int                    CORE           = 0,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    READ_LATENCY   = 0,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = DATA_WIDTH'(32'h00000013)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    readEnable,
    input  logic [ADDR_WIDTH-1:0]   readAddress,
    output logic [DATA_WIDTH-1:0]   readData,
    output logic                    readValid,
    input  logic                    writeEnable,
    input  logic [DATA_WIDTH/8-1:0] writeByteEnable,
    input  logic [ADDR_WIDTH-1:0]   writeAddress,
    input  logic [DATA_WIDTH-1:0]   writeData,
    output logic                    busy,
    input  logic                    report
);

    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // Reject unsupported configurations at elaboration time.
    if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : gBadLatency
        $fatal(1, "bsram_be_clear: READ_LATENCY must be 0 or 1, got %0d", READ_LATENCY);
    end
    if (DATA_WIDTH % 8 != 0) begin : gBadWidth
        $fatal(1, "bsram_be_clear: DATA_WIDTH must be a multiple of 8, got %0d", DATA_WIDTH);
    end

    typedef enum logic {IDLE, CLEAR} stateType;

    stateType              state;
    stateType              nextState;
    logic [ADDR_WIDTH-1:0] clearAddr;
    logic [31:0]           cycles;
    logic                  readAccept;
    logic [DATA_WIDTH-1:0] mergedWord;
    logic [DATA_WIDTH-1:0] sram [MEM_DEPTH];

    // State register: reset restarts the sweep from the beginning, even mid-sweep.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? CLEAR : IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state: leave CLEAR once the last word has been written.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        nextState = state;
        if (state == CLEAR && clearAddr == '1) begin
            nextState = IDLE;
        end
    end

    // Outputs of the FSM: busy also covers the reset cycles when a sweep will follow.
    always_comb begin
        busy       = reset ? CLEAR_ON_RESET : (state == CLEAR);
        readAccept = readEnable && !reset && (state == IDLE);
    end

    // Sweep address counter; advances once per CLEAR cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            clearAddr <= '0;
        end else if (state == CLEAR) begin
            clearAddr <= clearAddr + ADDR_WIDTH'(1);
        end
    end

    // Memory write port: sweep writes take priority, user writes only when idle.
    // NOTE: the array itself is never reset; the clear sweep initialises it instead.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                sram[clearAddr] <= CLEAR_VALUE;
            end else if (writeEnable) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (writeByteEnable[i]) begin
                        sram[writeAddress][8*i +: 8] <= writeData[8*i +: 8];
                    end
                end
            end
        end
    end

    // Write-first merge: strobed bytes of a same-address write replace stored bytes.
    always_comb begin
        mergedWord = sram[readAddress];
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (writeEnable && writeByteEnable[i] && readAddress == writeAddress) begin
                mergedWord[8*i +: 8] = writeData[8*i +: 8];
            end
        end
    end

    if (READ_LATENCY == 0) begin : gReadComb
        // Same-cycle read: zero when not accepted.
        always_comb begin
            readData  = readAccept ? mergedWord : '0;
            readValid = readAccept;
        end
    end else begin : gReadReg
        // Registered read: data holds its last value when no read is accepted.
        always_ff @(posedge clock) begin
            if (reset) begin
                readData  <= '0;
                readValid <= 1'b0;
            end else begin
                readValid <= readAccept;
                if (readAccept) begin
                    readData <= mergedWord;
                end
            end
        end
    end

    // Free-running cycle counter and optional state report.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
        if (report) begin
            $display("core %0d cycle %0d state %s busy %b | rd en %b addr %h data %h | wr en %b addr %h data %h be %b",
                     CORE, cycles, state.name(), busy, readEnable, readAddress, readData,
                     writeEnable, writeAddress, writeData, writeByteEnable);
        end
    end

endmodule
